// File: rtl/bpu_pht_ctrl.sv
// PHT controller: init sweep, lookup/update arbitration with starvation guard,
// read-modify-write counter updates with write-to-read forwarding.
//   state | meaning
//   BOOT  | one idle cycle after reset release
//   INIT  | write INIT_VAL to every entry, one per cycle
//   RUN   | serve lookups and updates; init_done high
module bpu_pht_ctrl #(
  parameter int ADDR       = 9,
  parameter int CTR_W      = 2,
  parameter int INIT_VAL   = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             lookup_valid,
  output logic             lookup_ready,
  input  logic [ADDR-1:0]  lookup_idx,
  output logic             pred_valid,
  output logic             pred_taken,
  output logic [CTR_W-1:0] pred_ctr,
  input  logic             upd_valid,
  output logic             upd_ready,
  input  logic [ADDR-1:0]  upd_idx,
  input  logic             upd_taken,
  output logic             init_done,
  output logic             ram_re,
  output logic [ADDR-1:0]  ram_raddr,
  input  logic [CTR_W-1:0] ram_rdata,
  output logic             ram_we,
  output logic [ADDR-1:0]  ram_waddr,
  output logic [CTR_W-1:0] ram_wdata
);

  localparam int DEPTH = 2**ADDR;
  localparam int SW    = $clog2(STARVE_MAX + 1);
  localparam logic [CTR_W-1:0] CTR_MAX = {CTR_W{1'b1}};
  localparam logic [CTR_W-1:0] INIT_C  = CTR_W'(INIT_VAL);

  typedef enum logic [1:0] {BOOT, INIT, RUN} state_t;

  state_t            state_q, state_d;
  logic [ADDR-1:0]   sweep_q;
  logic [SW-1:0]     starve_q;
  logic              s1_valid, s1_upd, s1_taken;
  logic [ADDR-1:0]   s1_idx;
  logic              fwd_valid;
  logic [CTR_W-1:0]  fwd_data;
  logic [CTR_W-1:0]  pred_hold;
  logic [CTR_W-1:0]  d_eff, d_sat;
  logic              run, starved;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= BOOT;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      BOOT:    state_d = INIT;
      INIT:    if (sweep_q == ADDR'(DEPTH - 1)) state_d = RUN;
      RUN:     state_d = RUN;
      default: state_d = BOOT;
    endcase
  end

  assign run       = (state_q == RUN);
  assign init_done = run;
  assign starved   = (starve_q == SW'(STARVE_MAX));

  // A starved update pre-empts lookups until it is accepted.
  assign upd_ready    = run && upd_valid && (starved || !lookup_valid);
  assign lookup_ready = run && lookup_valid && !(starved && upd_valid);
  assign ram_re       = upd_ready || lookup_ready;
  assign ram_raddr    = upd_ready ? upd_idx : (lookup_ready ? lookup_idx : '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sweep_q   <= '0;
      starve_q  <= '0;
      s1_valid  <= 1'b0;
      s1_upd    <= 1'b0;
      s1_taken  <= 1'b0;
      s1_idx    <= '0;
      fwd_valid <= 1'b0;
      fwd_data  <= '0;
      pred_hold <= '0;
    end else begin
      if (state_q == INIT) sweep_q <= sweep_q + 1'b1;
      if (upd_ready)                                    starve_q <= '0;
      else if (run && upd_valid && !starved)            starve_q <= starve_q + 1'b1;
      s1_valid  <= ram_re;
      s1_upd    <= upd_ready;
      s1_taken  <= upd_ready && upd_taken;
      s1_idx    <= ram_raddr;
      fwd_valid <= ram_re && ram_we && (ram_raddr == ram_waddr);
      fwd_data  <= ram_wdata;
      pred_hold <= pred_ctr;
    end
  end

  assign d_eff = fwd_valid ? fwd_data : ram_rdata;

  always_comb begin
    d_sat = d_eff;
    if (s1_taken) begin
      if (d_eff != CTR_MAX) d_sat = d_eff + CTR_W'(1);
    end else begin
      if (d_eff != '0)      d_sat = d_eff - CTR_W'(1);
    end
  end

  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = '0;
    ram_wdata = '0;
    if (state_q == INIT) begin
      ram_we    = 1'b1;
      ram_waddr = sweep_q;
      ram_wdata = INIT_C;
    end else if (run && s1_valid && s1_upd) begin
      ram_we    = 1'b1;
      ram_waddr = s1_idx;
      ram_wdata = d_sat;
    end
  end

  assign pred_valid = s1_valid && !s1_upd;
  assign pred_ctr   = pred_valid ? d_eff : pred_hold;
  assign pred_taken = pred_ctr[CTR_W-1];

endmodule
